io_leds: RTL and testbench

IO_LEDS -- requirements
Module: io_leds

---
 rtl/io_leds.sv | 205 ++++++++++++++++++++
 tb/tb_io_leds.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_leds.sv
// ---------------------------------------------------------------------------
// io_leds -- memory-mapped LED driver with blink and optional PWM dimming.
//
// Register map (LEDS_A):
//   0 VALUE  (R/W, N_LEDS bits)   1 MODE   (R/W, bit0 BLINK_EN, bit1 PWM_ON)
//   2 PERIOD (R/W, BLINK_W bits)  3 DUTY   (R/W, 8 bits)
//   4 SET    (W, VALUE |= WD)     5 CLR    (W, VALUE &= ~WD)
//   6 STATUS (R, bit0 blink phase, bits 15:8 PWM counter)
//   7..15 read 0, writes ignored.
//
// Ports:
//   CLK      - clock, all state updates on the rising edge
//   RESET    - asynchronous active-high reset
//   LEDS_WE  - single-cycle register write strobe
//   LEDS_A   - register address (4 bits)
//   LEDS_WD  - write data (32 bits)
//   LEDS_RD  - read data, combinational from LEDS_A
//   LEDS     - registered pin drive, 1 = lit
//
// Build option: define LEDS_PWM_EN to implement the PWM counter, the DUTY
// register and MODE.PWM_ON. Without it those read 0 and the gate is always 1.
// ---------------------------------------------------------------------------
module io_leds #(
  parameter int N_LEDS  = 8,
  parameter int BLINK_W = 24
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LEDS_WE,
  input  logic [3:0]        LEDS_A,
  input  logic [31:0]       LEDS_WD,
  output logic [31:0]       LEDS_RD,
  output logic [N_LEDS-1:0] LEDS
);

  // Architectural state
  logic [N_LEDS-1:0]  value_r;
  logic               blink_en_r;
  logic [BLINK_W-1:0] period_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               phase_r;
  logic [N_LEDS-1:0]  leds_r;

  // Next-state and decode signals
  logic [N_LEDS-1:0]  value_nxt_s;
  logic [BLINK_W-1:0] blink_cnt_nxt_s;
  logic               phase_nxt_s;
  logic [N_LEDS-1:0]  leds_nxt_s;
  logic               blink_restart_s;
  logic               gate_s;
  logic               pwm_on_s;
  logic [7:0]         duty_s;
  logic [7:0]         pwm_cnt_s;
  logic [31:0]        rd_s;

  logic wr_value_s;
  logic wr_mode_s;
  logic wr_period_s;
  logic wr_set_s;
  logic wr_clr_s;

  // Not every write-data bit lands in a register; fold them so the bus is consumed.
  logic unused_wd_s;
  assign unused_wd_s = ^LEDS_WD;

  assign wr_value_s  = LEDS_WE && (LEDS_A == 4'd0);
  assign wr_mode_s   = LEDS_WE && (LEDS_A == 4'd1);
  assign wr_period_s = LEDS_WE && (LEDS_A == 4'd2);
  assign wr_set_s    = LEDS_WE && (LEDS_A == 4'd4);
  assign wr_clr_s    = LEDS_WE && (LEDS_A == 4'd5);

  // A new period or the enabling edge of blink restarts the blink cycle lit.
  assign blink_restart_s = wr_period_s || (wr_mode_s && LEDS_WD[0] && !blink_en_r);

`ifdef LEDS_PWM_EN
  logic       wr_duty_s;
  logic       pwm_on_r;
  logic [7:0] duty_r;
  logic [7:0] pwm_cnt_r;

  assign wr_duty_s = LEDS_WE && (LEDS_A == 4'd3);
  assign pwm_on_s  = pwm_on_r;
  assign duty_s    = duty_r;
  assign pwm_cnt_s = pwm_cnt_r;

  // PWM gate: DUTY 0 and 255 are forced fully off / fully on.
  always_comb begin
    gate_s = 1'b1;
    if (pwm_on_r) begin
      if (duty_r == 8'd0) begin
        gate_s = 1'b0;
      end else if (duty_r == 8'hFF) begin
        gate_s = 1'b1;
      end else begin
        gate_s = (pwm_cnt_r < duty_r);
      end
    end else begin
      gate_s = 1'b1;
    end
  end

  // PWM counter, DUTY and PWM_ON storage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pwm_on_r  <= 1'b0;
      duty_r    <= 8'd0;
      pwm_cnt_r <= 8'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
      if (wr_mode_s) begin
        pwm_on_r <= LEDS_WD[1];
      end
      if (wr_duty_s) begin
        duty_r <= LEDS_WD[7:0];
      end
    end
  end
`else
  assign pwm_on_s  = 1'b0;
  assign duty_s    = 8'd0;
  assign pwm_cnt_s = 8'd0;
  assign gate_s    = 1'b1;
`endif

  // VALUE next state: direct write, bit set or bit clear.
  always_comb begin
    value_nxt_s = value_r;
    if (wr_value_s) begin
      value_nxt_s = LEDS_WD[N_LEDS-1:0];
    end else if (wr_set_s) begin
      value_nxt_s = value_r | LEDS_WD[N_LEDS-1:0];
    end else if (wr_clr_s) begin
      value_nxt_s = value_r & ~LEDS_WD[N_LEDS-1:0];
    end else begin
      value_nxt_s = value_r;
    end
  end

  // Blink counter and phase; PERIOD=0 makes the phase toggle every cycle.
  always_comb begin
    blink_cnt_nxt_s = blink_cnt_r;
    phase_nxt_s     = phase_r;
    if (blink_restart_s) begin
      blink_cnt_nxt_s = {BLINK_W{1'b0}};
      phase_nxt_s     = 1'b1;
    end else if (blink_en_r) begin
      if (blink_cnt_r == period_r) begin
        blink_cnt_nxt_s = {BLINK_W{1'b0}};
        phase_nxt_s     = ~phase_r;
      end else begin
        blink_cnt_nxt_s = blink_cnt_r + BLINK_W'(1'b1);
        phase_nxt_s     = phase_r;
      end
    end else begin
      blink_cnt_nxt_s = {BLINK_W{1'b0}};
      phase_nxt_s     = 1'b1;
    end
  end

  // Pin drive from the pre-edge VALUE, phase and gate.
  assign leds_nxt_s = value_r & {N_LEDS{phase_r & gate_s}};

  // Register file, blink state and pin register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      value_r     <= {N_LEDS{1'b0}};
      blink_en_r  <= 1'b0;
      period_r    <= {BLINK_W{1'b1}};
      blink_cnt_r <= {BLINK_W{1'b0}};
      phase_r     <= 1'b1;
      leds_r      <= {N_LEDS{1'b0}};
    end else begin
      value_r     <= value_nxt_s;
      blink_cnt_r <= blink_cnt_nxt_s;
      phase_r     <= phase_nxt_s;
      leds_r      <= leds_nxt_s;
      if (wr_mode_s) begin
        blink_en_r <= LEDS_WD[0];
      end
      if (wr_period_s) begin
        period_r <= LEDS_WD[BLINK_W-1:0];
      end
    end
  end

  // Read mux; unimplemented bits and addresses read 0.
  always_comb begin
    rd_s = 32'd0;
    case (LEDS_A)
      4'd0: rd_s[N_LEDS-1:0]  = value_r;
      4'd1: rd_s[1:0]         = {pwm_on_s, blink_en_r};
      4'd2: rd_s[BLINK_W-1:0] = period_r;
      4'd3: rd_s[7:0]         = duty_s;
      4'd6: begin
        rd_s[0]    = phase_r;
        rd_s[15:8] = pwm_cnt_s;
      end
      default: rd_s = 32'd0;
    endcase
  end

  assign LEDS_RD = rd_s;
  assign LEDS    = leds_r;

endmodule

// File: tb/tb_io_leds.sv
// ---------------------------------------------------------------------------
// tb_io_leds -- scoreboard bench for io_leds (default parameters).
// The stimulus process advances a behavioural model on each rising edge,
// drives the next inputs and queues the expected LEDS / LEDS_RD; a monitor
// on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_io_leds;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        LEDS_WE = 1'b0;
  logic [3:0]  LEDS_A = 4'd0;
  logic [31:0] LEDS_WD = 32'd0;
  logic [31:0] LEDS_RD;
  logic [7:0]  LEDS;

  always #5 CLK = ~CLK;

  io_leds #(.N_LEDS(8), .BLINK_W(24)) dut (
    .CLK(CLK), .RESET(RESET), .LEDS_WE(LEDS_WE), .LEDS_A(LEDS_A),
    .LEDS_WD(LEDS_WD), .LEDS_RD(LEDS_RD), .LEDS(LEDS)
  );

  typedef struct packed {
    logic [7:0]  leds;
    logic [31:0] rd;
    logic [3:0]  a;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state (plain integers)
  int m_value, m_blink_en, m_pwm_on, m_period, m_duty, m_bcnt, m_phase, m_pcnt, m_leds;

  // Inputs held during the current cycle
  logic        cur_rst = 1'b1;
  logic        cur_we  = 1'b0;
  logic [3:0]  cur_a   = 4'd0;
  logic [31:0] cur_wd  = 32'd0;

  task automatic model_reset();
    m_value = 0; m_blink_en = 0; m_pwm_on = 0; m_period = 32'h00FF_FFFF;
    m_duty = 0; m_bcnt = 0; m_phase = 1; m_pcnt = 0; m_leds = 0;
  endtask

  // One clock edge of the behaviour: pin from old state, then state update.
  task automatic model_step(input logic we, input logic [3:0] a, input logic [31:0] wd);
    int gate;
    int new_leds;
    int wdi;
    bit restart;
    wdi  = int'(wd);
    gate = 1;
`ifdef LEDS_PWM_EN
    if (m_pwm_on != 0) begin
      if (m_duty == 0)        gate = 0;
      else if (m_duty == 255) gate = 1;
      else                    gate = (m_pcnt < m_duty) ? 1 : 0;
    end
`endif
    new_leds = (m_phase != 0 && gate != 0) ? m_value : 0;

    restart = we && (a == 4'd2 || (a == 4'd1 && wd[0] && m_blink_en == 0));
    if (restart) begin
      m_bcnt = 0; m_phase = 1;
    end else if (m_blink_en != 0) begin
      if (m_bcnt == m_period) begin
        m_bcnt = 0; m_phase = 1 - m_phase;
      end else begin
        m_bcnt = m_bcnt + 1;
      end
    end else begin
      m_bcnt = 0; m_phase = 1;
    end
`ifdef LEDS_PWM_EN
    m_pcnt = (m_pcnt + 1) % 256;
`endif
    if (we) begin
      case (a)
        4'd0: m_value = wdi & 8'hFF;
        4'd1: begin
          m_blink_en = wdi & 1;
`ifdef LEDS_PWM_EN
          m_pwm_on = (wdi >> 1) & 1;
`endif
        end
        4'd2: m_period = wdi & 32'h00FF_FFFF;
`ifdef LEDS_PWM_EN
        4'd3: m_duty = wdi & 8'hFF;
`endif
        4'd4: m_value = (m_value | wdi) & 8'hFF;
        4'd5: m_value = (m_value & ~wdi) & 8'hFF;
        default: ;
      endcase
    end
    m_leds = new_leds;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return 32'(m_value);
      4'd1:    return 32'(m_blink_en + 2 * m_pwm_on);
      4'd2:    return 32'(m_period);
      4'd3:    return 32'(m_duty);
      4'd6:    return 32'(m_phase + 256 * m_pcnt);
      default: return 32'd0;
    endcase
  endfunction

  // Advance one cycle, drive new inputs, queue what the DUT must show.
  task automatic drive(input logic rst, input logic we, input logic [3:0] a, input logic [31:0] wd);
    exp_t e;
    @(posedge CLK);
    if (cur_rst) model_reset();
    else         model_step(cur_we, cur_a, cur_wd);
    #1;
    cur_rst = rst; cur_we = we; cur_a = a; cur_wd = wd;
    RESET = rst; LEDS_WE = we; LEDS_A = a; LEDS_WD = wd;
    if (rst) model_reset();
    e.leds = m_leds[7:0];
    e.rd   = model_read(a);
    e.a    = a;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n, input logic [3:0] a);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, a, 32'd0);
  endtask

  // Monitor: compare whatever the stimulus queued for this cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (LEDS !== e.leds) begin
        n_fail++;
        $display("FAIL leds @%0t: got %h, want %h", $time, LEDS, e.leds);
      end
      n_chk++;
      if (LEDS_RD !== e.rd) begin
        n_fail++;
        $display("FAIL rd a=%0d @%0t: got %h, want %h", e.a, $time, LEDS_RD, e.rd);
      end
    end
  end

  initial begin
    model_reset();
    #2 RESET = 1'b1;

    // Reset contents readback across the map
    for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, 4'(a), 32'd0);
    idle(2, 4'd0);

    // VALUE write to pin
    drive(1'b0, 1'b1, 4'd0, 32'h0000_00A5);
    idle(4, 4'd0);

    // SET then CLR
    drive(1'b0, 1'b1, 4'd0, 32'h0000_000F);
    drive(1'b0, 1'b1, 4'd4, 32'h0000_00F0);
    idle(1, 4'd0);
    drive(1'b0, 1'b1, 4'd5, 32'h0000_003C);
    idle(2, 4'd0);

    // Blink with PERIOD=3
    drive(1'b0, 1'b1, 4'd0, 32'h0000_00FF);
    drive(1'b0, 1'b1, 4'd2, 32'd3);
    drive(1'b0, 1'b1, 4'd1, 32'd1);
    idle(20, 4'd6);
    drive(1'b0, 1'b1, 4'd2, 32'd0);
    idle(6, 4'd6);
    drive(1'b0, 1'b1, 4'd1, 32'd0);
    idle(4, 4'd6);

    // PWM dimming at DUTY 64, 0 and 255
    drive(1'b0, 1'b1, 4'd0, 32'h0000_0001);
    drive(1'b0, 1'b1, 4'd3, 32'd64);
    drive(1'b0, 1'b1, 4'd1, 32'd2);
    idle(300, 4'd6);
    drive(1'b0, 1'b1, 4'd3, 32'd0);
    idle(40, 4'd3);
    drive(1'b0, 1'b1, 4'd3, 32'd255);
    idle(270, 4'd6);

    // Reset pulsed in the middle of a blink period
    drive(1'b0, 1'b1, 4'd0, 32'h0000_00FF);
    drive(1'b0, 1'b1, 4'd2, 32'd5);
    drive(1'b0, 1'b1, 4'd1, 32'd3);
    idle(8, 4'd6);
    drive(1'b1, 1'b0, 4'd0, 32'd0);
    drive(1'b1, 1'b0, 4'd2, 32'd0);
    drive(1'b1, 1'b0, 4'd1, 32'd0);
    idle(6, 4'd6);

    // Writes to unused addresses leave every register alone
    drive(1'b0, 1'b1, 4'd0, 32'h0000_005A);
    for (int a = 7; a < 16; a++) drive(1'b0, 1'b1, 4'(a), $urandom);
    for (int a = 0; a < 16; a++) drive(1'b0, 1'b0, 4'(a), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  ra;
      logic [31:0] rwd;
      ra  = 4'($urandom_range(0, 15));
      rwd = $urandom;
      if (ra == 4'd2 && $urandom_range(0, 15) != 0) rwd = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0)      drive(1'b1, 1'b0, ra, 32'd0);
      else if ($urandom_range(0, 3) == 0)   drive(1'b0, 1'b1, ra, rwd);
      else                                  drive(1'b0, 1'b0, ra, 32'd0);
    end

    idle(1, 4'd0);
    @(negedge CLK);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
